// File: rtl/cp1_responder.sv
// Coprocessor-1 responder: 32-entry FP register file plus a multi-cycle single-precision add/sub.
// Define CP1_FLAGS_EN to add sticky overflow/underflow flags with a flag_clr input.

module cp1_responder #(
    parameter int NREG = 32,
    parameter int W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef CP1_FLAGS_EN
    input  logic                    flag_clr,
    output logic                    flag_ovf,
    output logic                    flag_unf,
`endif
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [$clog2(NREG)-1:0] req_fd,
    input  logic [$clog2(NREG)-1:0] req_fs,
    input  logic [$clog2(NREG)-1:0] req_ft,
    input  logic [W-1:0]            req_wdata,
    output logic                    rsp_valid,
    output logic [W-1:0]            rsp_data
);

    localparam int IW = $clog2(NREG);

    localparam logic [1:0] OP_ADD_S = 2'b00;
    localparam logic [1:0] OP_SUB_S = 2'b01;
    localparam logic [1:0] OP_MTC1  = 2'b10;
    localparam logic [1:0] OP_MFC1  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  rf_q [NREG];
    logic [W-1:0]  rf_d [NREG];
    logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic          is_sub_q, is_sub_d;
    logic [IW-1:0] fd_q, fd_d;
    logic          sign_big_q, sign_big_d, sign_small_q, sign_small_d;
    logic [7:0]    exp_big_q, exp_big_d, exp_small_q, exp_small_d;
    logic [23:0]   man_big_q, man_big_d, man_small_q, man_small_d;
    logic [24:0]   sum_q, sum_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;

    logic          b_sign;
    logic [23:0]   a_man, b_man;
    logic [30:0]   a_mag, b_mag;
    logic [7:0]    align_shift;
    logic [4:0]    lzc;
    logic          lzc_found;
    logic [23:0]   norm_shifted;
    logic          norm_zero, norm_ovf, norm_unf;
    logic [W-1:0]  norm_result;

    // Flush-to-zero unpack: an exponent of zero clears the hidden bit and the magnitude.
    always_comb begin
        b_sign = op_b_q[31] ^ is_sub_q;
        a_man  = (op_a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, op_a_q[22:0]};
        b_man  = (op_b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, op_b_q[22:0]};
        a_mag  = {op_a_q[30:23], a_man[22:0]};
        b_mag  = {op_b_q[30:23], b_man[22:0]};
        align_shift = exp_big_q - exp_small_q;
    end

    always_comb begin
        lzc       = 5'd0;
        lzc_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lzc_found && sum_q[i]) begin
                lzc       = 5'(23 - i);
                lzc_found = 1'b1;
            end
        end
        norm_shifted = sum_q[23:0] << lzc;
        norm_zero    = (sum_q == 25'd0);
        norm_ovf     = sum_q[24] && (exp_big_q >= 8'd254);
        norm_unf     = !sum_q[24] && !norm_zero && (exp_big_q <= {3'b000, lzc});
        if (norm_zero) begin
            norm_result = '0;
        end else if (norm_ovf) begin
            norm_result = {sign_big_q, 8'hFF, 23'd0};
        end else if (sum_q[24]) begin
            norm_result = {sign_big_q, exp_big_q + 8'd1, sum_q[23:1]};
        end else if (norm_unf) begin
            norm_result = {sign_big_q, 31'd0};
        end else begin
            norm_result = {sign_big_q, exp_big_q - {3'b000, lzc}, norm_shifted[22:0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        is_sub_d     = is_sub_q;
        fd_d         = fd_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        exp_big_d    = exp_big_q;
        exp_small_d  = exp_small_q;
        man_big_d    = man_big_q;
        man_small_d  = man_small_q;
        sum_d        = sum_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_MTC1: begin
                            rf_d[req_fd] = req_wdata;
                            rsp_valid_d  = 1'b1;
                            rsp_data_d   = req_wdata;
                        end
                        OP_MFC1: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rf_q[req_fs];
                        end
                        default: begin
                            op_a_d   = rf_q[req_fs];
                            op_b_d   = rf_q[req_ft];
                            is_sub_d = (req_op == OP_SUB_S);
                            fd_d     = req_fd;
                            state_d  = S_UNPACK;
                        end
                    endcase
                end
            end
            S_UNPACK: begin
                if (b_mag > a_mag) begin
                    sign_big_d   = b_sign;
                    exp_big_d    = op_b_q[30:23];
                    man_big_d    = b_man;
                    sign_small_d = op_a_q[31];
                    exp_small_d  = op_a_q[30:23];
                    man_small_d  = a_man;
                end else begin
                    sign_big_d   = op_a_q[31];
                    exp_big_d    = op_a_q[30:23];
                    man_big_d    = a_man;
                    sign_small_d = b_sign;
                    exp_small_d  = op_b_q[30:23];
                    man_small_d  = b_man;
                end
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                man_small_d = (align_shift >= 8'd25) ? 24'd0 : (man_small_q >> align_shift);
                state_d     = S_ADD;
            end
            S_ADD: begin
                // The swap guarantees big >= small, so the difference never goes negative.
                if (sign_big_q != sign_small_q) begin
                    sum_d = {1'b0, man_big_q} - {1'b0, man_small_q};
                end else begin
                    sum_d = {1'b0, man_big_q} + {1'b0, man_small_q};
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                rf_d[fd_q]  = norm_result;
                rsp_valid_d = 1'b1;
                rsp_data_d  = norm_result;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            is_sub_q     <= 1'b0;
            fd_q         <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            exp_big_q    <= '0;
            exp_small_q  <= '0;
            man_big_q    <= '0;
            man_small_q  <= '0;
            sum_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            rf_q         <= rf_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            is_sub_q     <= is_sub_d;
            fd_q         <= fd_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            exp_big_q    <= exp_big_d;
            exp_small_q  <= exp_small_d;
            man_big_q    <= man_big_d;
            man_small_q  <= man_small_d;
            sum_q        <= sum_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef CP1_FLAGS_EN
    logic flag_ovf_q, flag_ovf_d, flag_unf_q, flag_unf_d;

    // A set in the NORM cycle overrides a simultaneous clear.
    always_comb begin
        flag_ovf_d = flag_ovf_q;
        flag_unf_d = flag_unf_q;
        if (flag_clr) begin
            flag_ovf_d = 1'b0;
            flag_unf_d = 1'b0;
        end
        if (state_q == S_NORM) begin
            if (norm_ovf) flag_ovf_d = 1'b1;
            if (norm_unf) flag_unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
        end else begin
            flag_ovf_q <= flag_ovf_d;
            flag_unf_q <= flag_unf_d;
        end
    end

    assign flag_ovf = flag_ovf_q;
    assign flag_unf = flag_unf_q;
`endif

endmodule

// File: tb/tb_cp1_responder.sv
// Directed testbench for cp1_responder: moves, add/sub arithmetic, handshake and reset abort.
// Flag checks are compiled in when CP1_FLAGS_EN is defined.

module tb_cp1_responder;

    localparam logic [1:0] OP_ADD_S = 2'b00;
    localparam logic [1:0] OP_SUB_S = 2'b01;
    localparam logic [1:0] OP_MTC1  = 2'b10;
    localparam logic [1:0] OP_MFC1  = 2'b11;

    // An ADD/SUB accepted in cycle 0 shows rsp_valid in cycle 5, after four busy cycles.
    localparam int LAT_MOVE  = 1;
    localparam int LAT_ARITH = 5;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_fd, req_fs, req_ft;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
`ifdef CP1_FLAGS_EN
    logic        flag_clr;
    logic        flag_ovf;
    logic        flag_unf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    cp1_responder dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CP1_FLAGS_EN
        .flag_clr  (flag_clr),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_fd    (req_fd),
        .req_fs    (req_fs),
        .req_ft    (req_ft),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1, "[TB] simulation timeout");
    end

    // Issues one op from an idle cycle and waits (bounded) for its response pulse.
    task automatic do_op(input logic [1:0] op, input logic [4:0] fd, input logic [4:0] fs,
                         input logic [4:0] ft, input logic [31:0] wdata,
                         output logic [31:0] data, output int lat);
        int i;
        req_valid = 1'b1;
        req_op    = op;
        req_fd    = fd;
        req_fs    = fs;
        req_ft    = ft;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat  = 0;
        data = 'x;
        i    = 1;
        while (lat == 0 && i <= 10) begin
            if (rsp_valid) begin
                lat  = i;
                data = rsp_data;
            end else begin
                @(posedge clk); #1;
                i++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          l;
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        vectors++;
        if (rsp_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", rsp_data);
        end
`ifdef CP1_FLAGS_EN
        vectors++;
        if ({flag_ovf, flag_unf} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 00", {flag_ovf, flag_unf});
        end
`endif
        do_op(OP_MFC1, 5'd0, 5'd9, 5'd0, 32'h0, d, l);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_reg_f9: got %h expected 00000000", d);
        end
    endtask

    task automatic test_move();
        logic [31:0] d;
        int          l;
        do_op(OP_MTC1, 5'd5, 5'd0, 5'd0, 32'h41200000, d, l);
        vectors++;
        if (l !== LAT_MOVE || d !== 32'h41200000) begin
            miscompares++;
            $display("[TB] FAIL mtc1_f5: got lat %0d data %h expected lat %0d data 41200000", l, d, LAT_MOVE);
        end
        do_op(OP_MFC1, 5'd0, 5'd5, 5'd0, 32'h0, d, l);
        vectors++;
        if (l !== LAT_MOVE || d !== 32'h41200000) begin
            miscompares++;
            $display("[TB] FAIL mfc1_f5: got lat %0d data %h expected lat %0d data 41200000", l, d, LAT_MOVE);
        end
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h41200000) begin
            miscompares++;
            $display("[TB] FAIL rsp_pulse_hold: got valid %b data %h expected valid 0 data 41200000", rsp_valid, rsp_data);
        end
        do_op(OP_MTC1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, d, l);
        do_op(OP_MFC1, 5'd0, 5'd0, 5'd0, 32'h0, d, l);
        vectors++;
        if (d !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL mfc1_f0: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_add();
        logic [31:0] d;
        int          l;
        do_op(OP_MTC1, 5'd1, 5'd0, 5'd0, 32'h3F800000, d, l);
        do_op(OP_MTC1, 5'd2, 5'd0, 5'd0, 32'h40000000, d, l);
        do_op(OP_ADD_S, 5'd3, 5'd1, 5'd2, 32'h0, d, l);
        vectors++;
        if (l !== LAT_ARITH || d !== 32'h40400000) begin
            miscompares++;
            $display("[TB] FAIL add_1p2: got lat %0d data %h expected lat %0d data 40400000", l, d, LAT_ARITH);
        end
        do_op(OP_MFC1, 5'd0, 5'd3, 5'd0, 32'h0, d, l);
        vectors++;
        if (d !== 32'h40400000) begin
            miscompares++;
            $display("[TB] FAIL add_f3_written: got %h expected 40400000", d);
        end
    endtask

    task automatic test_sub();
        logic [31:0] d;
        int          l;
        do_op(OP_SUB_S, 5'd4, 5'd1, 5'd1, 32'h0, d, l);
        vectors++;
        if (l !== LAT_ARITH || d !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL sub_self: got lat %0d data %h expected lat %0d data 00000000", l, d, LAT_ARITH);
        end
        do_op(OP_MTC1, 5'd6, 5'd0, 5'd0, 32'h3FC00000, d, l);
        do_op(OP_MTC1, 5'd8, 5'd0, 5'd0, 32'h3E800000, d, l);
        do_op(OP_SUB_S, 5'd9, 5'd6, 5'd8, 32'h0, d, l);
        vectors++;
        if (d !== 32'h3FA00000) begin
            miscompares++;
            $display("[TB] FAIL sub_1p5_0p25: got %h expected 3fa00000", d);
        end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    // Each vector loads f10/f11, writes the result back into f10 (fd == fs) and reads it back.
    task automatic test_arith_table();
        vec_t        tbl [10];
        logic [31:0] d;
        int          l;
        tbl[0] = '{OP_ADD_S, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        tbl[1] = '{OP_SUB_S, 32'h80C00000, 32'h80800000, 32'h80000000};
        tbl[2] = '{OP_ADD_S, 32'h4B000000, 32'h3FFFFFFF, 32'h4B000001};
        tbl[3] = '{OP_ADD_S, 32'h00000000, 32'hC0A00000, 32'hC0A00000};
        tbl[4] = '{OP_ADD_S, 32'h00000001, 32'h3F800000, 32'h3F800000};
        tbl[5] = '{OP_SUB_S, 32'h00000000, 32'h40000000, 32'hC0000000};
        tbl[6] = '{OP_ADD_S, 32'h80000000, 32'h80000000, 32'h00000000};
        tbl[7] = '{OP_ADD_S, 32'h3F800000, 32'hBF800000, 32'h00000000};
        tbl[8] = '{OP_ADD_S, 32'hC0000000, 32'h3F800000, 32'hBF800000};
        tbl[9] = '{OP_ADD_S, 32'h3FC00000, 32'h3FC00000, 32'h40400000};
        for (int i = 0; i < 10; i++) begin
            do_op(OP_MTC1, 5'd10, 5'd0, 5'd0, tbl[i].a, d, l);
            do_op(OP_MTC1, 5'd11, 5'd0, 5'd0, tbl[i].b, d, l);
            do_op(tbl[i].op, 5'd10, 5'd10, 5'd11, 32'h0, d, l);
            vectors++;
            if (l !== LAT_ARITH || d !== tbl[i].res) begin
                miscompares++;
                $display("[TB] FAIL arith[%0d] rsp: got lat %0d data %h expected lat %0d data %h", i, l, d, LAT_ARITH, tbl[i].res);
            end
            do_op(OP_MFC1, 5'd0, 5'd10, 5'd0, 32'h0, d, l);
            vectors++;
            if (d !== tbl[i].res) begin
                miscompares++;
                $display("[TB] FAIL arith[%0d] reg: got %h expected %h", i, d, tbl[i].res);
            end
        end
    endtask

`ifdef CP1_FLAGS_EN
    task automatic test_flags();
        logic [31:0] d;
        int          l;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        do_op(OP_MTC1, 5'd13, 5'd0, 5'd0, 32'h7F7FFFFF, d, l);
        do_op(OP_ADD_S, 5'd14, 5'd13, 5'd13, 32'h0, d, l);
        vectors++;
        if ({flag_ovf, flag_unf} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL flag_ovf_set: got %b expected 10", {flag_ovf, flag_unf});
        end
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        vectors++;
        if ({flag_ovf, flag_unf} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL flag_clr: got %b expected 00", {flag_ovf, flag_unf});
        end
        do_op(OP_MTC1, 5'd13, 5'd0, 5'd0, 32'h80C00000, d, l);
        do_op(OP_MTC1, 5'd15, 5'd0, 5'd0, 32'h80800000, d, l);
        do_op(OP_SUB_S, 5'd14, 5'd13, 5'd15, 32'h0, d, l);
        vectors++;
        if ({flag_ovf, flag_unf} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL flag_unf_set: got %b expected 01", {flag_ovf, flag_unf});
        end
    endtask
`endif

    // A second request is held on req_valid while the add runs and must wait for the idle cycle.
    task automatic test_back_to_back();
        logic [31:0] d;
        int          l;
        int          busy;
        int          early;
        req_valid = 1'b1;
        req_op    = OP_ADD_S;
        req_fd    = 5'd3;
        req_fs    = 5'd1;
        req_ft    = 5'd2;
        @(posedge clk); #1;
        req_op    = OP_MTC1;
        req_fd    = 5'd12;
        req_wdata = 32'h11111111;
        busy  = 0;
        early = 0;
        while (!req_ready && busy < 10) begin
            if (rsp_valid) early++;
            busy++;
            @(posedge clk); #1;
        end
        vectors++;
        if (busy !== 4 || early !== 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy: got %0d busy cycles %0d early rsp expected 4 busy 0 early", busy, early);
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_rsp: got valid %b data %h expected valid 1 data 40400000", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h11111111) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_rsp: got valid %b data %h expected valid 1 data 11111111", rsp_valid, rsp_data);
        end
        do_op(OP_MFC1, 5'd0, 5'd12, 5'd0, 32'h0, d, l);
        vectors++;
        if (d !== 32'h11111111) begin
            miscompares++;
            $display("[TB] FAIL b2b_f12: got %h expected 11111111", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int          l;
        int          seen;
        do_op(OP_MTC1, 5'd7, 5'd0, 5'd0, 32'h12345678, d, l);
        req_valid = 1'b1;
        req_op    = OP_ADD_S;
        req_fd    = 5'd7;
        req_fs    = 5'd1;
        req_ft    = 5'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_state: got ready %b valid %b data %h expected ready 1 valid 0 data 00000000", req_ready, rsp_valid, rsp_data);
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_rsp: got %0d rsp pulses expected 0", seen);
        end
        do_op(OP_MFC1, 5'd0, 5'd7, 5'd0, 32'h0, d, l);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_f7: got %h expected 00000000", d);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_fd    = 5'd0;
        req_fs    = 5'd0;
        req_ft    = 5'd0;
        req_wdata = 32'h0;
`ifdef CP1_FLAGS_EN
        flag_clr  = 1'b0;
`endif
        test_reset();
        test_move();
        test_add();
        test_sub();
        test_arith_table();
`ifdef CP1_FLAGS_EN
        test_flags();
`endif
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
